// File: rtl/md5_msg_padder.sv
// UART-to-MD5 message padder: collects bytes until the "EOF" terminator, pads, emits 512-bit blocks.
// Optional build macro MD5_PAD_STRIP_CRLF_EN discards 0x0D/0x0A bytes on arrival.
module md5_msg_padder #(
  parameter int          CNT_W = 32,
  parameter logic [7:0]  EOF_0 = 8'h45,
  parameter logic [7:0]  EOF_1 = 8'h4F,
  parameter logic [7:0]  EOF_2 = 8'h46
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   rx_byte,
  input  logic         received,
  output logic [511:0] blk_data,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic         blk_first,
  output logic         blk_last,
  output logic         busy,
  output logic         overflow
);

  // state    | meaning
  // COLLECT  | moving queued message bytes into the block buffer
  // SEND     | full message block offered to the core
  // PAD      | writing 0x80 then zeros up to byte 56
  // PAD_SEND | padding overflowed the block; intermediate block offered
  // LEN      | writing the 64-bit bit length into bytes 56..63
  // FINAL    | last block offered; handshake ends the message
  typedef enum logic [2:0] {COLLECT, SEND, PAD, PAD_SEND, LEN, FINAL} state_t;

  state_t           state_q, state_d;
  logic [511:0]     buf_q;
  logic [5:0]       idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       m_q, m_nxt;
  logic [7:0]       q_mem [3];
  logic [7:0]       q_nxt [3];
  logic [1:0]       q_cnt, cnt_ap;
  logic             busy_q, first_q, pad80_q, ovf_q;

  logic             byte_in, handshake, accept, drop, eof_hit;
  logic             pop, pad_wr, len_wr, done;
  logic [1:0]       n_push;
  logic [7:0]       push_b [3];

`ifdef MD5_PAD_STRIP_CRLF_EN
  assign byte_in = received && (rx_byte != 8'h0D) && (rx_byte != 8'h0A);
`else
  assign byte_in = received;
`endif

  assign blk_valid = (state_q == SEND) || (state_q == PAD_SEND) || (state_q == FINAL);
  assign blk_last  = (state_q == FINAL);
  assign blk_first = blk_valid && first_q;
  assign blk_data  = buf_q;
  assign busy      = busy_q;
  assign overflow  = ovf_q;
  assign handshake = blk_valid && blk_ready;

  // Terminator matcher: held bytes are always the constant prefix chars, so only m is stored.
  always_comb begin
    n_push    = 2'd0;
    push_b[0] = rx_byte;
    push_b[1] = 8'h00;
    push_b[2] = 8'h00;
    m_nxt     = m_q;
    eof_hit   = 1'b0;
    case (m_q)
      2'd0: begin
        if (rx_byte == EOF_0) m_nxt = 2'd1;
        else                  n_push = 2'd1;
      end
      2'd1: begin
        if (rx_byte == EOF_1) begin
          m_nxt = 2'd2;
        end else begin
          push_b[0] = EOF_0;
          if (rx_byte == EOF_0) begin
            n_push = 2'd1;
          end else begin
            push_b[1] = rx_byte;
            n_push    = 2'd2;
            m_nxt     = 2'd0;
          end
        end
      end
      2'd2: begin
        if (rx_byte == EOF_2) begin
          eof_hit = 1'b1;
          m_nxt   = 2'd0;
        end else begin
          push_b[0] = EOF_0;
          push_b[1] = EOF_1;
          if (rx_byte == EOF_0) begin
            n_push = 2'd2;
            m_nxt  = 2'd1;
          end else begin
            push_b[2] = rx_byte;
            n_push    = 2'd3;
            m_nxt     = 2'd0;
          end
        end
      end
      default: m_nxt = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    pad_wr  = 1'b0;
    len_wr  = 1'b0;
    done    = 1'b0;
    case (state_q)
      COLLECT: begin
        if (q_cnt != 2'd0) begin
          pop = 1'b1;
          if (idx_q == 6'd63) state_d = SEND;
        end else if (busy_q) begin
          state_d = PAD;
        end
      end
      // Buffer is free again on the handshake edge, so a queued byte may land in byte 0 then.
      SEND: begin
        if (handshake) begin
          state_d = COLLECT;
          pop     = (q_cnt != 2'd0);
        end
      end
      PAD: begin
        if (pad80_q && (idx_q == 6'd56)) begin
          state_d = LEN;
        end else begin
          pad_wr = 1'b1;
          if (idx_q == 6'd63) state_d = PAD_SEND;
        end
      end
      PAD_SEND: if (handshake) state_d = PAD;
      LEN: begin
        len_wr  = 1'b1;
        state_d = FINAL;
      end
      FINAL: begin
        if (handshake) begin
          done    = 1'b1;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    q_nxt  = q_mem;
    cnt_ap = q_cnt;
    if (pop) begin
      q_nxt[0] = q_mem[1];
      q_nxt[1] = q_mem[2];
      q_nxt[2] = 8'h00;
      cnt_ap   = q_cnt - 2'd1;
    end
    accept = byte_in && !busy_q && (({1'b0, cnt_ap} + {1'b0, n_push}) <= 3'd3);
    drop   = byte_in && !accept;
    if (accept) begin
      for (int s = 0; s < 3; s++) begin
        for (int k = 0; k < 3; k++) begin
          if ((k < int'(n_push)) && ((int'(cnt_ap) + k) == s)) q_nxt[s] = push_b[k];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= COLLECT;
      buf_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      m_q     <= '0;
      q_cnt   <= '0;
      for (int i = 0; i < 3; i++) q_mem[i] <= 8'h00;
      busy_q  <= 1'b0;
      first_q <= 1'b1;
      pad80_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_mem   <= q_nxt;
      q_cnt   <= accept ? (cnt_ap + n_push) : cnt_ap;
      if (accept) begin
        m_q <= m_nxt;
        if (eof_hit) busy_q <= 1'b1;
      end
      if (drop) ovf_q <= 1'b1;
      if (pop) begin
        buf_q[{idx_q, 3'b000} +: 8] <= q_mem[0];
        idx_q <= idx_q + 6'd1;
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (pad_wr) begin
        buf_q[{idx_q, 3'b000} +: 8] <= pad80_q ? 8'h00 : 8'h80;
        pad80_q <= 1'b1;
        idx_q   <= idx_q + 6'd1;
      end
      if (len_wr) begin
        buf_q[511:448] <= 64'({cnt_q, 3'b000});
        idx_q          <= 6'd0;
      end
      if (handshake) first_q <= 1'b0;
      if (done) begin
        buf_q   <= '0;
        idx_q   <= '0;
        cnt_q   <= '0;
        m_q     <= '0;
        busy_q  <= 1'b0;
        pad80_q <= 1'b0;
        first_q <= 1'b1;
      end
    end
  end

endmodule
